stage_8_butterfly_addsub: RTL

STAGE_8_BUTTERFLY_ADDSUB -- requirements
Module: stage_8_butterfly_addsub

---
 rtl/stage_8_butterfly_addsub.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/stage_8_butterfly_addsub.sv
// Radix-2 NTT butterfly stage: per lane pair, (a+b) mod q and (a-b) mod q.
// Two-cycle registered datapath plus frame-tracking control for start/busy.
module stage_8_butterfly_addsub #(
  parameter int unsigned DATA_WIDTH_PER_INPUT = 28,
  parameter int unsigned INPUT_PER_CYCLE      = 64,
  parameter int unsigned CYCLES_PER_FRAME     = 16,
  parameter int unsigned MODULUS              = 268369921
) (
  input  logic clk,
  input  logic rst,
  input  logic [DATA_WIDTH_PER_INPUT-1:0]
    inData_0,  inData_1,  inData_2,  inData_3,  inData_4,  inData_5,  inData_6,  inData_7,
    inData_8,  inData_9,  inData_10, inData_11, inData_12, inData_13, inData_14, inData_15,
    inData_16, inData_17, inData_18, inData_19, inData_20, inData_21, inData_22, inData_23,
    inData_24, inData_25, inData_26, inData_27, inData_28, inData_29, inData_30, inData_31,
    inData_32, inData_33, inData_34, inData_35, inData_36, inData_37, inData_38, inData_39,
    inData_40, inData_41, inData_42, inData_43, inData_44, inData_45, inData_46, inData_47,
    inData_48, inData_49, inData_50, inData_51, inData_52, inData_53, inData_54, inData_55,
    inData_56, inData_57, inData_58, inData_59, inData_60, inData_61, inData_62, inData_63,
  input  logic in_start,
  output logic [DATA_WIDTH_PER_INPUT-1:0]
    outData_0,  outData_1,  outData_2,  outData_3,  outData_4,  outData_5,  outData_6,  outData_7,
    outData_8,  outData_9,  outData_10, outData_11, outData_12, outData_13, outData_14, outData_15,
    outData_16, outData_17, outData_18, outData_19, outData_20, outData_21, outData_22, outData_23,
    outData_24, outData_25, outData_26, outData_27, outData_28, outData_29, outData_30, outData_31,
    outData_32, outData_33, outData_34, outData_35, outData_36, outData_37, outData_38, outData_39,
    outData_40, outData_41, outData_42, outData_43, outData_44, outData_45, outData_46, outData_47,
    outData_48, outData_49, outData_50, outData_51, outData_52, outData_53, outData_54, outData_55,
    outData_56, outData_57, outData_58, outData_59, outData_60, outData_61, outData_62, outData_63,
  output logic out_start,
  output logic out_busy
);

  localparam int unsigned W     = DATA_WIDTH_PER_INPUT;
  localparam int unsigned WP1   = W + 1;
  localparam int unsigned LANES = INPUT_PER_CYCLE;
  localparam int unsigned PAIRS = LANES / 2;
  localparam int unsigned CNT_W = $clog2(CYCLES_PER_FRAME);

  localparam logic [WP1-1:0]   Q_EXT = WP1'(MODULUS);
  localparam logic [W-1:0]     Q_W   = W'(MODULUS);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CYCLES_PER_FRAME - 1);

  typedef enum logic {IDLE, RUN} state_e;

  logic [W-1:0]   lane_in [LANES];
  logic [W-1:0]   res_q   [LANES];
  logic [WP1-1:0] sum_q   [PAIRS];
  logic [W-1:0]   dif_q   [PAIRS];
  logic           brw_q   [PAIRS];

  state_e         state_q;
  logic [CNT_W-1:0] cnt_q;
  logic           start_q;

  assign lane_in[0]  = inData_0;  assign lane_in[1]  = inData_1;  assign lane_in[2]  = inData_2;  assign lane_in[3]  = inData_3;
  assign lane_in[4]  = inData_4;  assign lane_in[5]  = inData_5;  assign lane_in[6]  = inData_6;  assign lane_in[7]  = inData_7;
  assign lane_in[8]  = inData_8;  assign lane_in[9]  = inData_9;  assign lane_in[10] = inData_10; assign lane_in[11] = inData_11;
  assign lane_in[12] = inData_12; assign lane_in[13] = inData_13; assign lane_in[14] = inData_14; assign lane_in[15] = inData_15;
  assign lane_in[16] = inData_16; assign lane_in[17] = inData_17; assign lane_in[18] = inData_18; assign lane_in[19] = inData_19;
  assign lane_in[20] = inData_20; assign lane_in[21] = inData_21; assign lane_in[22] = inData_22; assign lane_in[23] = inData_23;
  assign lane_in[24] = inData_24; assign lane_in[25] = inData_25; assign lane_in[26] = inData_26; assign lane_in[27] = inData_27;
  assign lane_in[28] = inData_28; assign lane_in[29] = inData_29; assign lane_in[30] = inData_30; assign lane_in[31] = inData_31;
  assign lane_in[32] = inData_32; assign lane_in[33] = inData_33; assign lane_in[34] = inData_34; assign lane_in[35] = inData_35;
  assign lane_in[36] = inData_36; assign lane_in[37] = inData_37; assign lane_in[38] = inData_38; assign lane_in[39] = inData_39;
  assign lane_in[40] = inData_40; assign lane_in[41] = inData_41; assign lane_in[42] = inData_42; assign lane_in[43] = inData_43;
  assign lane_in[44] = inData_44; assign lane_in[45] = inData_45; assign lane_in[46] = inData_46; assign lane_in[47] = inData_47;
  assign lane_in[48] = inData_48; assign lane_in[49] = inData_49; assign lane_in[50] = inData_50; assign lane_in[51] = inData_51;
  assign lane_in[52] = inData_52; assign lane_in[53] = inData_53; assign lane_in[54] = inData_54; assign lane_in[55] = inData_55;
  assign lane_in[56] = inData_56; assign lane_in[57] = inData_57; assign lane_in[58] = inData_58; assign lane_in[59] = inData_59;
  assign lane_in[60] = inData_60; assign lane_in[61] = inData_61; assign lane_in[62] = inData_62; assign lane_in[63] = inData_63;

  // Stage 1 keeps raw sum and borrow-flagged difference; stage 2 folds each back into [0, q-1].
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < PAIRS; k++) begin
        sum_q[k]       <= '0;
        dif_q[k]       <= '0;
        brw_q[k]       <= 1'b0;
        res_q[2*k]     <= '0;
        res_q[2*k + 1] <= '0;
      end
    end else begin
      for (int k = 0; k < PAIRS; k++) begin
        sum_q[k]              <= WP1'(lane_in[2*k]) + WP1'(lane_in[2*k + 1]);
        {brw_q[k], dif_q[k]}  <= WP1'(lane_in[2*k]) - WP1'(lane_in[2*k + 1]);
        res_q[2*k]            <= (sum_q[k] >= Q_EXT) ? W'(sum_q[k] - Q_EXT) : W'(sum_q[k]);
        res_q[2*k + 1]        <= brw_q[k] ? (dif_q[k] + Q_W) : dif_q[k];
      end
    end
  end

  // Frame tracker; in_start always (re)starts at beat 0, including on the final beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_start) begin
            state_q <= RUN;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          if (in_start) begin
            cnt_q <= '0;
          end else if (cnt_q == LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // state_q already lags in_start by one edge, so one more register lines busy up with the data.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q   <= 1'b0;
      out_start <= 1'b0;
      out_busy  <= 1'b0;
    end else begin
      start_q   <= in_start;
      out_start <= start_q;
      out_busy  <= (state_q == RUN);
    end
  end

  assign outData_0  = res_q[0];  assign outData_1  = res_q[1];  assign outData_2  = res_q[2];  assign outData_3  = res_q[3];
  assign outData_4  = res_q[4];  assign outData_5  = res_q[5];  assign outData_6  = res_q[6];  assign outData_7  = res_q[7];
  assign outData_8  = res_q[8];  assign outData_9  = res_q[9];  assign outData_10 = res_q[10]; assign outData_11 = res_q[11];
  assign outData_12 = res_q[12]; assign outData_13 = res_q[13]; assign outData_14 = res_q[14]; assign outData_15 = res_q[15];
  assign outData_16 = res_q[16]; assign outData_17 = res_q[17]; assign outData_18 = res_q[18]; assign outData_19 = res_q[19];
  assign outData_20 = res_q[20]; assign outData_21 = res_q[21]; assign outData_22 = res_q[22]; assign outData_23 = res_q[23];
  assign outData_24 = res_q[24]; assign outData_25 = res_q[25]; assign outData_26 = res_q[26]; assign outData_27 = res_q[27];
  assign outData_28 = res_q[28]; assign outData_29 = res_q[29]; assign outData_30 = res_q[30]; assign outData_31 = res_q[31];
  assign outData_32 = res_q[32]; assign outData_33 = res_q[33]; assign outData_34 = res_q[34]; assign outData_35 = res_q[35];
  assign outData_36 = res_q[36]; assign outData_37 = res_q[37]; assign outData_38 = res_q[38]; assign outData_39 = res_q[39];
  assign outData_40 = res_q[40]; assign outData_41 = res_q[41]; assign outData_42 = res_q[42]; assign outData_43 = res_q[43];
  assign outData_44 = res_q[44]; assign outData_45 = res_q[45]; assign outData_46 = res_q[46]; assign outData_47 = res_q[47];
  assign outData_48 = res_q[48]; assign outData_49 = res_q[49]; assign outData_50 = res_q[50]; assign outData_51 = res_q[51];
  assign outData_52 = res_q[52]; assign outData_53 = res_q[53]; assign outData_54 = res_q[54]; assign outData_55 = res_q[55];
  assign outData_56 = res_q[56]; assign outData_57 = res_q[57]; assign outData_58 = res_q[58]; assign outData_59 = res_q[59];
  assign outData_60 = res_q[60]; assign outData_61 = res_q[61]; assign outData_62 = res_q[62]; assign outData_63 = res_q[63];

endmodule
